// File: rtl/aurora_hls_config_regs.sv
// Configuration/status register block for the Aurora HLS channels: read-only core
// configuration, shadowed RX FIFO thresholds with atomic commit, and sticky FIFO status.
module aurora_hls_config_regs #(
    parameter int NUM_CHANNELS       = 2,
    parameter int HAS_TKEEP          = 1,
    parameter int HAS_TLAST          = 1,
    parameter int FIFO_WIDTH         = 64,
    parameter int RX_FIFO_DEPTH      = 512,
    parameter int RX_EQ_MODE_BIN     = 0,
    parameter int INS_LOSS_NYQ       = 8,
    parameter int PROG_FULL_DEFAULT  = 384,
    parameter int PROG_EMPTY_DEFAULT = 128
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [5:0]                   req_addr,
    input  logic [31:0]                  req_wdata,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [31:0]                  resp_rdata,
    output logic                         resp_err,
    input  logic [NUM_CHANNELS-1:0]      ovf_evt,
    input  logic [NUM_CHANNELS-1:0]      udf_evt,
    output logic [32*NUM_CHANNELS-1:0]   fifo_thresholds,
    output logic [NUM_CHANNELS-1:0]      thresholds_update
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int DEPTH_LOG2 = $clog2(RX_FIFO_DEPTH);
    localparam logic [31:0] CONFIG_WORD = {2'b00, 8'(NUM_CHANNELS), 5'(INS_LOSS_NYQ),
                                           2'(RX_EQ_MODE_BIN), 4'(DEPTH_LOG2), 9'(FIFO_WIDTH),
                                           1'(HAS_TLAST), 1'(HAS_TKEEP)};
    localparam logic [31:0] THRESH_DEFAULT = {16'(PROG_FULL_DEFAULT), 16'(PROG_EMPTY_DEFAULT)};

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t state, state_next;

    logic [31:0] shadow_q [NUM_CHANNELS];
    logic [31:0] active_q [NUM_CHANNELS];
    logic [7:0]  ovf_cnt_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ovf_q, udf_q, rej_q, update_q;

    logic            accept;
    logic [3:0]      ch;
    logic [1:0]      reg_sel;
    logic            ch_ok;
    logic [CH_W-1:0] ch_idx;
    logic [31:0]     sel_shadow;
    logic            shadow_ok;
    logic            wr_shadow, commit_ok, commit_rej, wr_status;
    logic [31:0]     rd_data;
    logic            rd_err;
    logic [NUM_CHANNELS-1:0] hit;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign accept     = req_valid && req_ready;
    assign ch         = req_addr[5:2];
    assign reg_sel    = req_addr[1:0];
    assign ch_ok      = ({1'b0, ch} < 5'(NUM_CHANNELS));
    assign ch_idx     = ch[CH_W-1:0];
    assign sel_shadow = shadow_q[ch_idx];
    assign shadow_ok  = (sel_shadow[15:0] < sel_shadow[31:16]) &&
                        ({16'b0, sel_shadow[31:16]} < 32'(RX_FIFO_DEPTH));

    // Request decode; side-effect strobes are qualified per channel through hit[].
    always_comb begin
        rd_data    = 32'b0;
        rd_err     = 1'b0;
        wr_shadow  = 1'b0;
        commit_ok  = 1'b0;
        commit_rej = 1'b0;
        wr_status  = 1'b0;
        if (!ch_ok) begin
            rd_err = 1'b1;
        end else if (!req_write) begin
            case (reg_sel)
                2'd0:    rd_data = CONFIG_WORD;
                2'd1:    rd_data = shadow_q[ch_idx];
                2'd2:    rd_data = active_q[ch_idx];
                default: rd_data = {16'b0, ovf_cnt_q[ch_idx], 5'b0,
                                    rej_q[ch_idx], udf_q[ch_idx], ovf_q[ch_idx]};
            endcase
        end else begin
            case (reg_sel)
                2'd1: wr_shadow = 1'b1;
                2'd2: begin
                    commit_ok  = req_wdata[0] && shadow_ok;
                    commit_rej = req_wdata[0] && !shadow_ok;
                    rd_err     = commit_rej;
                end
                2'd3:    wr_status = 1'b1;
                default: ;
            endcase
        end
        for (int c = 0; c < NUM_CHANNELS; c++)
            hit[c] = accept && ch_ok && (ch_idx == CH_W'(c));
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            resp_rdata <= 32'b0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_rdata <= rd_data;
            resp_err   <= rd_err;
        end
    end

    // Per-channel state; FIFO events are folded in every cycle and win over W1C.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                shadow_q[c]  <= THRESH_DEFAULT;
                active_q[c]  <= THRESH_DEFAULT;
                ovf_cnt_q[c] <= 8'd0;
            end
            ovf_q    <= '0;
            udf_q    <= '0;
            rej_q    <= '0;
            update_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (hit[c] && wr_shadow) shadow_q[c] <= req_wdata;
                if (hit[c] && commit_ok) active_q[c] <= shadow_q[c];
                update_q[c] <= hit[c] && commit_ok;
                ovf_q[c] <= ovf_evt[c] || (ovf_q[c] && !(hit[c] && wr_status && req_wdata[0]));
                udf_q[c] <= udf_evt[c] || (udf_q[c] && !(hit[c] && wr_status && req_wdata[1]));
                rej_q[c] <= (hit[c] && commit_rej) ||
                            (rej_q[c] && !(hit[c] && wr_status && req_wdata[2]));
                if (hit[c] && wr_status && req_wdata[31])
                    ovf_cnt_q[c] <= ovf_evt[c] ? 8'd1 : 8'd0;
                else if (ovf_evt[c] && ovf_cnt_q[c] != 8'hFF)
                    ovf_cnt_q[c] <= ovf_cnt_q[c] + 8'd1;
            end
        end
    end

    always_comb begin
        fifo_thresholds = '0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            fifo_thresholds[c*32 +: 32] = active_q[c];
    end

    assign thresholds_update = update_q;

endmodule

// File: tb/tb_aurora_hls_config_regs.sv
// Self-checking bench for aurora_hls_config_regs: directed scenarios plus randomized
// register traffic compared against a behavioural register-map model.
module tb_aurora_hls_config_regs;

    localparam int NCH   = 2;
    localparam int TKEEP = 1;
    localparam int TLAST = 1;
    localparam int FW    = 64;
    localparam int DEPTH = 512;
    localparam int EQ    = 0;
    localparam int INS   = 8;
    localparam int PFD   = 384;
    localparam int PED   = 128;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;
    logic            req_valid, req_ready, req_write;
    logic [5:0]      req_addr;
    logic [31:0]     req_wdata;
    logic            resp_valid, resp_ready;
    logic [31:0]     resp_rdata;
    logic            resp_err;
    logic [NCH-1:0]  ovf_evt, udf_evt;
    logic [32*NCH-1:0] fifo_thresholds;
    logic [NCH-1:0]  thresholds_update;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_shadow [NCH];
    logic [31:0] m_active [NCH];
    bit          m_ovf [NCH];
    bit          m_udf [NCH];
    bit          m_rej [NCH];
    int          m_cnt [NCH];

    always #5 ap_clk = ~ap_clk;

    aurora_hls_config_regs #(
        .NUM_CHANNELS(NCH), .HAS_TKEEP(TKEEP), .HAS_TLAST(TLAST), .FIFO_WIDTH(FW),
        .RX_FIFO_DEPTH(DEPTH), .RX_EQ_MODE_BIN(EQ), .INS_LOSS_NYQ(INS),
        .PROG_FULL_DEFAULT(PFD), .PROG_EMPTY_DEFAULT(PED)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ovf_evt(ovf_evt), .udf_evt(udf_evt),
        .fifo_thresholds(fifo_thresholds), .thresholds_update(thresholds_update)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cfg_word();
        int lg = 0;
        while ((1 << lg) < DEPTH) lg++;
        return 32'((NCH << 22) + (INS << 17) + (EQ << 15) + (lg << 11) +
                   (FW << 2) + (TLAST << 1) + TKEEP);
    endfunction

    function automatic logic [63:0] exp_thresholds();
        return {m_active[1], m_active[0]};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_shadow[c] = (PFD << 16) + PED;
            m_active[c] = (PFD << 16) + PED;
            m_ovf[c] = 0; m_udf[c] = 0; m_rej[c] = 0; m_cnt[c] = 0;
        end
    endtask

    // One clock edge of FIFO events, with optional status clears for channel clr_ch.
    task automatic model_events(input logic [NCH-1:0] om, input logic [NCH-1:0] um,
                                input int clr_ch, input logic [31:0] clr);
        for (int c = 0; c < NCH; c++) begin
            bit hitc = (c == clr_ch);
            m_ovf[c] = om[c] || (m_ovf[c] && !(hitc && clr[0]));
            m_udf[c] = um[c] || (m_udf[c] && !(hitc && clr[1]));
            m_rej[c] = m_rej[c] && !(hitc && clr[2]);
            if (hitc && clr[31]) m_cnt[c] = om[c] ? 1 : 0;
            else if (om[c])      m_cnt[c] = (m_cnt[c] >= 255) ? 255 : m_cnt[c] + 1;
        end
    endtask

    task automatic model_access(input bit wr, input logic [5:0] addr, input logic [31:0] wd,
                                input logic [NCH-1:0] om, input logic [NCH-1:0] um,
                                output logic [31:0] er, output logic ee,
                                output logic [NCH-1:0] eu);
        int ch = int'(addr[5:2]);
        int rg = int'(addr[1:0]);
        int pf, pe;
        int clr_ch = -1;
        er = 0; ee = 0; eu = 0;
        if (ch >= NCH) begin
            ee = 1;
        end else if (!wr) begin
            case (rg)
                0: er = cfg_word();
                1: er = m_shadow[ch];
                2: er = m_active[ch];
                default: er = 32'((m_cnt[ch] << 8) + (m_rej[ch] << 2) + (m_udf[ch] << 1) + m_ovf[ch]);
            endcase
        end else if (rg == 1) begin
            m_shadow[ch] = wd;
        end else if (rg == 2 && wd[0]) begin
            pf = int'(m_shadow[ch][31:16]);
            pe = int'(m_shadow[ch][15:0]);
            if (pe < pf && pf < DEPTH) begin
                m_active[ch] = m_shadow[ch];
                eu[ch] = 1'b1;
            end else begin
                ee = 1;
                m_rej[ch] = 1;
            end
        end else if (rg == 3) begin
            clr_ch = ch;
        end
        model_events(om, um, clr_ch, wd);
    endtask

    task automatic applyStimulus(input bit wr, input logic [5:0] addr, input logic [31:0] wd,
                                 input logic [NCH-1:0] om, input logic [NCH-1:0] um,
                                 output logic [31:0] rd, output logic er,
                                 output logic [NCH-1:0] up);
        @(negedge ap_clk);
        if (!req_ready) begin
            $display("[TB] FAIL req_ready observed=0 expected=1");
            $fatal(1, "[TB] block not idle");
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        ovf_evt = om; udf_evt = um;
        @(posedge ap_clk);
        @(negedge ap_clk);
        req_valid = 1'b0; ovf_evt = '0; udf_evt = '0;
        chk("resp_valid", 64'(resp_valid), 64'd1);
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        rd = resp_rdata; er = resp_err; up = thresholds_update;
        resp_ready = 1'b1;
        @(posedge ap_clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input bit wr, input logic [5:0] addr,
                               input logic [31:0] wd, input logic [NCH-1:0] om,
                               input logic [NCH-1:0] um, output logic [31:0] rd);
        logic [31:0] er;
        logic ee, e;
        logic [NCH-1:0] eu, u;
        model_access(wr, addr, wd, om, um, er, ee, eu);
        applyStimulus(wr, addr, wd, om, um, rd, e, u);
        chk({tag, "_rdata"}, 64'(rd), 64'(er));
        chk({tag, "_err"}, 64'(e), 64'(ee));
        chk({tag, "_update"}, 64'(u), 64'(eu));
        chk({tag, "_thresh"}, fifo_thresholds, exp_thresholds());
    endtask

    task automatic pulse_events(input logic [NCH-1:0] om, input logic [NCH-1:0] um);
        @(negedge ap_clk);
        ovf_evt = om; udf_evt = um;
        @(posedge ap_clk);
        model_events(om, um, -1, 32'd0);
        #1 ovf_evt = '0; udf_evt = '0;
    endtask

    initial begin
        logic [31:0] rd, wd;
        logic [5:0]  addr;
        logic [NCH-1:0] om, um;
        int rg;
        ap_rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; ovf_evt = '0; udf_evt = '0;
        model_reset();
        repeat (3) @(negedge ap_clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", 64'(resp_rdata), 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        chk("rst_update", 64'(thresholds_update), 64'd0);
        chk("rst_thresh", fifo_thresholds, 64'h0180_0080_0180_0080);
        ap_rst_n = 1'b1;

        checkOutput("cfg_ch0", 0, 6'h00, 32'd0, '0, '0, rd);
        checkOutput("cfg_ch1_write", 1, 6'h04, 32'hFFFF_FFFF, '0, '0, rd);

        checkOutput("ch1_shadow_wr", 1, 6'h05, 32'h0100_0020, '0, '0, rd);
        checkOutput("ch1_active_rd", 0, 6'h06, 32'd0, '0, '0, rd);
        chk("ch1_active_default", 64'(rd), 64'h0180_0080);
        checkOutput("ch1_shadow_rd", 0, 6'h05, 32'd0, '0, '0, rd);
        checkOutput("ch1_commit", 1, 6'h06, 32'h1, '0, '0, rd);
        chk("ch1_thresh_lit", 64'(fifo_thresholds[63:32]), 64'h0100_0020);
        @(negedge ap_clk);
        chk("ch1_update_one_cycle", 64'(thresholds_update), 64'd0);
        checkOutput("ch1_commit_noop", 1, 6'h06, 32'h0, '0, '0, rd);

        checkOutput("ch0_shadow_bad", 1, 6'h01, 32'h0040_0040, '0, '0, rd);
        checkOutput("ch0_commit_rej", 1, 6'h02, 32'h1, '0, '0, rd);
        checkOutput("ch0_status_rej", 0, 6'h03, 32'd0, '0, '0, rd);
        chk("ch0_status_rej_lit", 64'(rd), 64'h0000_0004);
        checkOutput("ch0_status_w1c_rej", 1, 6'h03, 32'h4, '0, '0, rd);

        for (int i = 0; i < 300; i++) pulse_events(2'b01, 2'b00);
        checkOutput("ch0_status_sat", 0, 6'h03, 32'd0, '0, '0, rd);
        chk("ch0_status_sat_lit", 64'(rd), 64'h0000_FF01);
        checkOutput("ch0_clr_vs_evt", 1, 6'h03, 32'h8000_0001, 2'b01, 2'b00, rd);
        checkOutput("ch0_status_after", 0, 6'h03, 32'd0, '0, '0, rd);
        chk("ch0_status_after_lit", 64'(rd), 64'h0000_0101);

        checkOutput("bad_ch_rd", 0, 6'h14, 32'd0, '0, '0, rd);
        checkOutput("bad_ch_wr", 1, 6'h15, 32'h0000_0010, '0, '0, rd);
        checkOutput("bad_ch_commit", 1, 6'h16, 32'h1, '0, '0, rd);

        for (int i = 0; i < 200; i++) begin
            addr[5:2] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(2, 15))
                                                     : 4'($urandom_range(0, NCH - 1));
            rg = $urandom_range(0, 3);
            addr[1:0] = 2'(rg);
            case (rg)
                1:       wd = {16'($urandom_range(0, 600)), 16'($urandom_range(0, 600))};
                2:       wd = {$urandom_range(0, 65535), 15'd0, 1'($urandom_range(0, 1))};
                default: wd = $urandom;
            endcase
            om = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            um = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            checkOutput("rand", 1'($urandom_range(0, 1)), addr, wd, om, um, rd);
            if ($urandom_range(0, 4) == 0) pulse_events(NCH'($urandom), NCH'($urandom));
        end

        // Stalled response, then asynchronous reset while the response is pending.
        @(negedge ap_clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h06;
        @(posedge ap_clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            chk("hold_resp_valid", 64'(resp_valid), 64'd1);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_rdata", 64'(resp_rdata), 64'(m_active[1]));
            if (i == 5) begin
                #2 ap_rst_n = 1'b0;
                #1;
                chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
                chk("midrst_req_ready", 64'(req_ready), 64'd1);
                chk("midrst_rdata", 64'(resp_rdata), 64'd0);
                chk("midrst_thresh", fifo_thresholds, 64'h0180_0080_0180_0080);
                break;
            end
        end
        model_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        checkOutput("post_rst_active", 0, 6'h06, 32'd0, '0, '0, rd);
        checkOutput("post_rst_status", 0, 6'h03, 32'd0, '0, '0, rd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
